// File: rtl/huff_freq_count.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : huff_freq_count                                                 |
// | Brief    : Per-symbol saturating counters, 3-bit weight quantizer and      |
// |            8-beat weight burst toward the Huffman tree builder.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module huff_freq_count #(
    parameter int CNT_W   = 6,   // must be >= 3
    parameter int W_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_char,
    input  logic       in_last,
    input  logic       in_mode,
    output logic       in_ready,
    input  logic       ht_ready,
    output logic       out_valid,
    output logic [2:0] out_weight,
    output logic       out_mode
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_count = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_emit  = 3'd3;
    localparam logic [2:0] c_st_gap   = 3'd4;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_seven   = CNT_W'(7);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [2:0]       r_beat;
    logic [2:0]       w_beat_nxt;
    logic [2:0]       w_beat_inc;
    logic [CNT_W-1:0] r_cnt [8];
    logic [2:0]       w_weight [8];
    logic             w_accept;
    logic             w_clear;
    logic             r_out_valid;
    logic [2:0]       r_out_weight;
    logic             r_out_mode;
    logic             w_out_valid_nxt;
    logic [2:0]       w_out_weight_nxt;

    assign in_ready   = (r_state == c_st_idle) || (r_state == c_st_count);
    assign w_accept   = in_valid && in_ready;
    assign w_beat_inc = r_beat + 3'd1;

    assign out_valid  = r_out_valid;
    assign out_weight = r_out_weight;
    assign out_mode   = r_out_mode;

    // Zero-count symbols map to weight 1 so every symbol still owns a leaf.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_weight
            logic [CNT_W-1:0] w_s;
            assign w_s = r_cnt[gi] >> W_SHIFT;
            assign w_weight[gi] = (w_s > c_seven) ? 3'd7 :
                                  (w_s == '0)     ? 3'd1 : w_s[2:0];
        end
    endgenerate

    always_comb begin
        w_state_nxt      = r_state;
        w_beat_nxt       = r_beat;
        w_out_valid_nxt  = 1'b0;
        w_out_weight_nxt = 3'd0;
        w_clear          = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_accept) w_state_nxt = in_last ? c_st_wait : c_st_count;
            end
            c_st_count: begin
                if (w_accept && in_last) w_state_nxt = c_st_wait;
            end
            c_st_wait: begin
                if (ht_ready) begin
                    w_state_nxt      = c_st_emit;
                    w_beat_nxt       = 3'd0;
                    w_out_valid_nxt  = 1'b1;
                    w_out_weight_nxt = w_weight[0];
                end
            end
            c_st_emit: begin
                if (r_beat == 3'd7) begin
                    w_state_nxt = c_st_gap;
                    w_beat_nxt  = 3'd0;
                end else begin
                    w_beat_nxt       = w_beat_inc;
                    w_out_valid_nxt  = 1'b1;
                    w_out_weight_nxt = w_weight[w_beat_inc];
                end
            end
            c_st_gap: begin
                w_state_nxt = c_st_idle;
                w_clear     = 1'b1;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_beat       <= 3'd0;
            r_out_valid  <= 1'b0;
            r_out_weight <= 3'd0;
            r_out_mode   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat       <= w_beat_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_weight <= w_out_weight_nxt;
            if (w_accept && in_last) r_out_mode <= in_mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_clear) begin
                    r_cnt[i] <= '0;
                end else if (w_accept && (in_char == 3'(i)) && (r_cnt[i] != c_cnt_max)) begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_one;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_huff_freq_count.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_huff_freq_count                                              |
// | Brief    : Scoreboard bench for huff_freq_count, default and narrow/shift  |
// |            instances driven by the same symbol stream.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_huff_freq_count;

    localparam int B_CNT_W = 3;
    localparam int B_SHIFT = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_char = 3'd0;
    logic       in_last = 1'b0;
    logic       in_mode = 1'b0;
    logic       ht_ready = 1'b0;

    logic       in_ready_a, out_valid_a, out_mode_a;
    logic [2:0] out_weight_a;
    logic       in_ready_b, out_valid_b, out_mode_b;
    logic [2:0] out_weight_b;

    int         tests = 0;
    int         fails = 0;
    int         occ [8];
    bit         exp_mode = 1'b0;
    logic [2:0] q_a [$];
    logic [2:0] q_b [$];
    logic [2:0] syms [$];
    logic [2:0] e_a, e_b;

    huff_freq_count dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char),
        .in_last(in_last), .in_mode(in_mode), .in_ready(in_ready_a),
        .ht_ready(ht_ready), .out_valid(out_valid_a), .out_weight(out_weight_a),
        .out_mode(out_mode_a)
    );

    huff_freq_count #(.CNT_W(B_CNT_W), .W_SHIFT(B_SHIFT)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char),
        .in_last(in_last), .in_mode(in_mode), .in_ready(in_ready_b),
        .ht_ready(ht_ready), .out_valid(out_valid_b), .out_weight(out_weight_b),
        .out_mode(out_mode_b)
    );

    always #5 clk = ~clk;

    // Reference weight: saturate the occurrence count, shift, then clamp to 1..7.
    function automatic logic [2:0] ref_weight(input int n, input int cnt_w, input int shift);
        int c, s, mx;
        mx = (1 << cnt_w) - 1;
        c  = (n > mx) ? mx : n;
        s  = c >> shift;
        if (s > 7) return 3'd7;
        if (s == 0) return 3'd1;
        return 3'(s);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_a) begin
                if (q_a.size() == 0) chk("a_unexpected_beat", 1, 0);
                else begin
                    e_a = q_a.pop_front();
                    chk("a_weight", int'(out_weight_a), int'(e_a));
                end
            end else chk("a_idle_weight", int'(out_weight_a), 0);
            if (out_valid_b) begin
                if (q_b.size() == 0) chk("b_unexpected_beat", 1, 0);
                else begin
                    e_b = q_b.pop_front();
                    chk("b_weight", int'(out_weight_b), int'(e_b));
                end
            end else chk("b_idle_weight", int'(out_weight_b), 0);
            chk("a_mode", int'(out_mode_a), int'(exp_mode));
            chk("b_mode", int'(out_mode_b), int'(exp_mode));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic junk;
        in_valid = 1'($urandom_range(0, 1));
        in_char  = 3'($urandom_range(0, 7));
        in_last  = 1'($urandom_range(0, 1));
        in_mode  = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_model;
        for (int k = 0; k < 8; k++) occ[k] = 0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        ht_ready = 1'b0;
        q_a.delete();
        q_b.delete();
        exp_mode = 1'b0;
        clear_model();
        #1;
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_out_weight", int'(out_weight_a), 0);
        chk("rst_out_mode", int'(out_mode_a), 0);
        chk("rst_in_ready", int'(in_ready_a), 1);
        chk("rst_out_valid_b", int'(out_valid_b), 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [2:0] ch, input bit last, input bit mode);
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_char  = ch;
        in_last  = last;
        in_mode  = mode;
        chk("frame_in_ready", int'(in_ready_a), 1);
        tick();
        occ[ch]++;
        if (last) begin
            for (int k = 0; k < 8; k++) begin
                q_a.push_back(ref_weight(occ[k], 6, 0));
                q_b.push_back(ref_weight(occ[k], B_CNT_W, B_SHIFT));
            end
            exp_mode = mode;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_frame(input int hold, input int abort_at);
        chk("wait_in_ready", int'(in_ready_a), 0);
        chk("wait_out_valid", int'(out_valid_a), 0);
        for (int h = 0; h < hold; h++) begin
            junk();
            tick();
            chk("hold_in_ready", int'(in_ready_a), 0);
            chk("hold_out_valid", int'(out_valid_a), 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        ht_ready = 1'b1;
        tick();
        chk("burst_start_a", int'(out_valid_a), 1);
        chk("burst_start_b", int'(out_valid_b), 1);
        for (int k = 1; k < 8; k++) begin
            junk();
            ht_ready = 1'($urandom_range(0, 1));
            tick();
            if (k == abort_at) begin
                do_reset();
                return;
            end
            chk("burst_beat", int'(out_valid_a), 1);
        end
        junk();
        tick();
        chk("gap_out_valid", int'(out_valid_a), 0);
        chk("gap_in_ready", int'(in_ready_a), 0);
        junk();
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        ht_ready = 1'b0;
        chk("post_gap_in_ready", int'(in_ready_a), 1);
        clear_model();
    endtask

    task automatic frame(input bit mode, input int hold, input int abort_at);
        ht_ready = (hold == 0);
        foreach (syms[i]) send(syms[i], (i == syms.size() - 1), mode);
        finish_frame(hold, abort_at);
        syms.delete();
    endtask

    task automatic rand_syms(input int n);
        for (int i = 0; i < n; i++) syms.push_back(3'($urandom_range(0, 7)));
    endtask

    initial begin
        int f1 [12];
        f1 = '{0, 0, 0, 1, 2, 3, 4, 4, 5, 6, 7, 7};
        clear_model();
        tick();
        do_reset();

        foreach (f1[i]) syms.push_back(3'(f1[i]));
        frame(1'b1, 0, -1);

        for (int i = 0; i < 21; i++) syms.push_back(3'd4);
        frame(1'b0, 0, -1);

        for (int i = 0; i < 10; i++) syms.push_back(3'd0);
        frame(1'b1, 0, -1);

        rand_syms(6);
        frame(1'b0, 5, -1);

        rand_syms(8);
        frame(1'b1, 0, 3);

        syms.push_back(3'd7);
        frame(1'b0, 0, -1);

        rand_syms(5);
        frame(1'b0, 0, -1);
        rand_syms(7);
        frame(1'b1, 0, -1);

        for (int r = 0; r < 20; r++) begin
            rand_syms(int'($urandom_range(1, 40)));
            frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1);
        end

        repeat (3) tick();
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
